regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: RESET_PRIO, default 0, meaning requester favoured at reset (0 = ALU, 1 = LSU).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alu_valid  input  1  ALU writeback request.
REQ-005 alu_rd  input  5  ALU destination register index.
REQ-006 alu_data  input  32  ALU writeback data.
REQ-007 alu_ready  output  1  ALU request accepted this cycle.
REQ-008 lsu_valid  input  1  LSU writeback request.
REQ-009 lsu_rd  input  5  LSU destination register index.
REQ-010 lsu_data  input  32  LSU writeback data.
REQ-011 lsu_ready  output  1  LSU request accepted this cycle.
REQ-012 issue_valid  input  1  instruction issued with pending destination.
REQ-013 issue_rd  input  5  destination index of issued instruction.
REQ-014 wr_en  output  32  registered one-hot register-file write enables.
REQ-015 wr_data  output  32  registered write data.
REQ-016 wr_rd  output  5  registered destination index (debug/forwarding).
REQ-017 busy  output  32  scoreboard: bit i set = register i has a write pending.

Function
REQ-018 Arbiter SHALL grant at most one requester per cycle; ready is combinational from valids and the priority pointer.
REQ-019 Transfer occurs when valid and ready are both high; ready SHALL never be high for a requester whose valid is low.
REQ-020 Only one valid: that requester SHALL be granted regardless of pointer.
REQ-021 Both valid: the requester named by the priority pointer SHALL be granted; the other sees ready low and holds its request.
REQ-022 After any transfer, pointer SHALL point to the non-granted requester (round-robin); with no transfer, pointer holds.
REQ-023 Latency: transfer in cycle N SHALL drive wr_en/wr_data/wr_rd in cycle N+1; one write per cycle sustained, no bubbles.
REQ-024 wr_en SHALL be the one-hot decode of the granted rd (bit rd set, all others 0).
REQ-025 rd = 0 transfer: SHALL be accepted (ready high), wr_en = 0 in cycle N+1; wr_data/wr_rd still update.
REQ-026 Cycle with no transfer: wr_en SHALL be 0 in the following cycle; wr_data and wr_rd hold prior values.
REQ-027 busy bit rd SHALL set the cycle after issue_valid with issue_rd = rd, rd != 0.
REQ-028 busy bit rd SHALL clear the cycle after a transfer with that rd.
REQ-029 Same-cycle issue and transfer to the same rd: set SHALL win (bit remains 1).
REQ-030 Same-cycle issue and transfer to different rd: both updates SHALL apply.
REQ-031 busy[0] SHALL be constant 0; issue_rd = 0 ignored.
REQ-032 A transfer to an rd whose busy bit is already 0 SHALL still write; the busy bit stays 0.

Reset
REQ-033 While rst is high: wr_en = 0, wr_data = 0, wr_rd = 0, busy = 0, pointer = RESET_PRIO; alu_ready and lsu_ready SHALL be 0.
REQ-034 Reset mid-operation SHALL discard any in-flight write: no wr_en pulse in the cycle after rst is sampled high.
REQ-035 First cycle after rst deasserts: normal arbitration SHALL apply from RESET_PRIO.

Verification
REQ-036 Reset, then alu_valid only, alu_rd = 5, data 0xDEADBEEF -> alu_ready = 1; next cycle wr_en = 0x00000020, wr_data = 0xDEADBEEF.
REQ-037 Both valid for 4 cycles, RESET_PRIO = 0, both hold valid -> grants in order ALU, LSU, ALU, LSU; wr_en pulses every cycle.
REQ-038 lsu_valid, lsu_rd = 0 -> lsu_ready = 1; next cycle wr_en = 0, wr_rd = 0.
REQ-039 issue_rd = 7, later ALU transfer rd = 7 -> busy[7] = 1 until the cycle after the transfer, then 0; also issue_rd = 7 in the same cycle as a transfer with rd = 7 -> busy[7] stays 1.
REQ-040 Transfer rd = 31 with rst asserted in the following cycle -> wr_en = 0 the cycle after rst is sampled high; busy = 0; pointer = RESET_PRIO.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and LSU writeback requests onto a single
// register-file write port with round-robin priority, and keeps a pending-write
// scoreboard (busy) set at issue and cleared at writeback.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/rd/data/ready  ALU writeback request channel (ready is combinational)
//   lsu_valid/rd/data/ready  LSU writeback request channel (ready is combinational)
//   issue_valid, issue_rd    issued instruction with a pending destination
//   wr_en                    registered one-hot write enables (bit 0 never set)
//   wr_data, wr_rd           registered write data and destination index
//   busy                     registered scoreboard, bit i = register i pending
module regfile_wb_arbiter #(
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] wr_en,
    output logic [31:0] wr_data,
    output logic [4:0]  wr_rd,
    output logic [31:0] busy
);

    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned DW   = 32;

    // Priority pointer: 0 = ALU favoured on contention, 1 = LSU favoured.
    logic            ptr;
    logic            xfer;
    logic [RW-1:0]   sel_rd;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] dec;
    logic [NREG-1:0] busy_next;

    // Grant: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            alu_ready = alu_valid && (!lsu_valid || !ptr);
            lsu_ready = lsu_valid && (!alu_valid || ptr);
        end
    end

    // Mux the granted request.
    always_comb begin
        xfer     = alu_ready || lsu_ready;
        sel_rd   = alu_ready ? alu_rd   : lsu_rd;
        sel_data = alu_ready ? alu_data : lsu_data;
    end

    // One-hot decode; register 0 is hardwired so it never gets an enable.
    always_comb begin
        dec = '0;
        if (sel_rd != RW'(0)) begin
            dec[sel_rd] = 1'b1;
        end
    end

    // Scoreboard update: clear on writeback first so a same-register issue wins.
    always_comb begin
        busy_next = busy;
        if (xfer) begin
            busy_next[sel_rd] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Output registers, pointer and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= '0;
            wr_data <= '0;
            wr_rd   <= '0;
            busy    <= '0;
            ptr     <= 1'(RESET_PRIO);
        end else begin
            wr_en <= xfer ? dec : '0;
            if (xfer) begin
                wr_data <= sel_data;
                wr_rd   <= sel_rd;
                // Point at whoever did not win this transfer.
                ptr     <= alu_ready;
            end
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] wr_en;
    logic [31:0] wr_data;
    logic [4:0]  wr_rd;
    logic [31:0] busy;

    regfile_wb_arbiter #(.RESET_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wr_en(wr_en), .wr_data(wr_data), .wr_rd(wr_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_favour;      // 0 = ALU next on contention, 1 = LSU
    logic [31:0] m_wr_en;
    logic [31:0] m_wr_data;
    logic [4:0]  m_wr_rd;
    bit          m_busy [32];
    logic        obs_ar, obs_lr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // One cycle: drive inputs, check grants, advance the model, check registered outputs.
    task automatic step(input bit r, input bit av, input int ard, input logic [31:0] ad,
                        input bit lv, input int lrd, input logic [31:0] ld,
                        input bit iv, input int ird);
        bit ea, el;
        rst = r; alu_valid = av; alu_rd = 5'(ard); alu_data = ad;
        lsu_valid = lv; lsu_rd = 5'(lrd); lsu_data = ld;
        issue_valid = iv; issue_rd = 5'(ird);
        #1;
        ea = !r && av && (!lv || m_favour == 0);
        el = !r && lv && !ea;
        obs_ar = alu_ready;
        obs_lr = lsu_ready;
        chk("alu_ready", 32'(alu_ready), 32'(ea));
        chk("lsu_ready", 32'(lsu_ready), 32'(el));
        if (r) begin
            m_favour = 0;
            m_wr_en = 0; m_wr_data = 0; m_wr_rd = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            int g_rd;
            g_rd = ea ? ard : lrd;
            m_wr_en = 0;
            if (ea || el) begin
                m_wr_data = ea ? ad : ld;
                m_wr_rd = 5'(g_rd);
                if (g_rd != 0) m_wr_en = 32'h1 << g_rd;
                m_favour = ea ? 1 : 0;
                m_busy[g_rd] = 0;
            end
            if (iv && ird != 0) m_busy[ird] = 1;
        end
        @(posedge clk);
        #1;
        chk("wr_en", wr_en, m_wr_en);
        chk("wr_data", wr_data, m_wr_data);
        chk("wr_rd", 32'(wr_rd), 32'(m_wr_rd));
        chk("busy", busy, busy_vec());
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit pend_a, pend_l;
        int a_rd, l_rd;
        logic [31:0] a_d, l_d;
        logic [31:0] grants;

        m_favour = 0;
        // Reset state
        idle(1);
        chk("rst_wr_en", wr_en, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);

        // Single ALU write to r5
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("alu5_ready", 32'(obs_ar), 32'h1);
        chk("alu5_wr_en", wr_en, 32'h0000_0020);
        chk("alu5_wr_data", wr_data, 32'hDEADBEEF);
        idle(0);
        chk("idle_wr_en", wr_en, 32'h0);
        chk("idle_hold_data", wr_data, 32'hDEADBEEF);

        // Contention: ALU, LSU, ALU, LSU from reset priority
        idle(1);
        grants = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 32'hA0 + 32'(k), 1, 2, 32'hB0 + 32'(k), 0, 0);
            grants[k] = obs_ar;
            chk("rr_pulse", 32'(wr_en != 0), 32'h1);
        end
        chk("rr_order", grants, 32'h5);

        // Write to r0 is accepted but enables nothing
        step(0, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
        chk("r0_ready", 32'(obs_lr), 32'h1);
        chk("r0_wr_en", wr_en, 32'h0);
        chk("r0_wr_rd", 32'(wr_rd), 32'h0);

        // Scoreboard on r7
        step(0, 0, 0, 0, 0, 0, 0, 1, 7);
        chk("busy7_set", 32'(busy[7]), 32'h1);
        idle(0);
        chk("busy7_hold", 32'(busy[7]), 32'h1);
        step(0, 1, 7, 32'h77, 0, 0, 0, 0, 0);
        chk("busy7_clr", 32'(busy[7]), 32'h0);
        step(0, 1, 7, 32'h78, 0, 0, 0, 1, 7);
        chk("busy7_setwins", 32'(busy[7]), 32'h1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("busy0_zero", 32'(busy[0]), 32'h0);

        // Reset right after an in-flight write to r31
        step(0, 1, 31, 32'h3131, 0, 0, 0, 1, 9);
        chk("r31_wr_en", wr_en, 32'h8000_0000);
        step(1, 1, 3, 32'h5, 1, 4, 32'h6, 1, 3);
        chk("rst_mid_ready", 32'({obs_ar, obs_lr}), 32'h0);
        chk("rst_mid_wr_en", wr_en, 32'h0);
        chk("rst_mid_busy", busy, 32'h0);
        step(0, 1, 3, 32'h5, 1, 4, 32'h6, 0, 0);
        chk("rst_mid_prio", 32'(obs_ar), 32'h1);

        // Random traffic; a refused requester holds its request
        pend_a = 0; pend_l = 0;
        a_rd = 0; l_rd = 0; a_d = 0; l_d = 0;
        for (int n = 0; n < 3000; n++) begin
            bit r, iv;
            int ird;
            r = ($urandom_range(0, 99) < 2);
            if (!pend_a) begin
                pend_a = ($urandom_range(0, 99) < 60);
                a_rd = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 31));
                a_d = $urandom;
            end
            if (!pend_l) begin
                pend_l = ($urandom_range(0, 99) < 60);
                l_rd = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 31));
                l_d = $urandom;
            end
            iv = ($urandom_range(0, 99) < 50);
            ird = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 31));
            step(r, pend_a, a_rd, a_d, pend_l, l_rd, l_d, iv, ird);
            if (obs_ar || r) pend_a = 0;
            if (obs_lr || r) pend_l = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
